// File: rtl/axi_rresp_router.sv
// AXI read-response router: in-order owner FIFO steering the slave R channel to AR winners.
// Optional orphan-response detection when RRESP_ORPHAN_DETECT_EN is defined.
module axi_rresp_router #(
   parameter  int NUM_MASTERS = 2,
   parameter  int DATA_WIDTH  = 32,
   parameter  int DEPTH       = 4,
   localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int PTR_W       = $clog2(DEPTH),
   localparam int CNT_W       = PTR_W + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] ar_grant,
   input  logic                   ar_fire,
   output logic                   ar_block,
   input  logic                   s_rvalid,
   output logic                   s_rready,
   input  logic [DATA_WIDTH-1:0]  s_rdata,
   input  logic [1:0]             s_rresp,
   input  logic                   s_rlast,
   output logic [NUM_MASTERS-1:0] m_rvalid,
   input  logic [NUM_MASTERS-1:0] m_rready,
   output logic [DATA_WIDTH-1:0]  m_rdata,
   output logic [1:0]             m_rresp,
   output logic                   m_rlast,
   output logic [CNT_W-1:0]       outstanding,
   output logic                   orphan_err
);

   logic [IDX_W-1:0]       r_fifo [DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;

   logic [IDX_W-1:0]       w_push_idx;
   logic [IDX_W-1:0]       w_head;
   logic                   w_nonempty;
   logic                   w_push;
   logic                   w_pop;
   logic [NUM_MASTERS-1:0] w_sel;

   assign w_nonempty  = (r_count != '0);
   assign ar_block    = (r_count == CNT_W'(DEPTH));
   assign w_push      = ar_fire && !ar_block;
   assign w_head      = r_fifo[r_rd_ptr];
   assign outstanding = r_count;

   assign m_rdata = s_rdata;
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;

   // Lowest set grant bit wins; an all-zero grant maps to master 0.
   always_comb begin
      w_push_idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (ar_grant[i]) w_push_idx = IDX_W'(i);
      end
   end

   always_comb begin
      w_sel    = '0;
      m_rvalid = '0;
      s_rready = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_sel[i]    = w_nonempty && (w_head == IDX_W'(i));
         m_rvalid[i] = w_sel[i] && s_rvalid;
         s_rready    = s_rready | (w_sel[i] && m_rready[i]);
      end
   end

   assign w_pop = s_rvalid && s_rready && s_rlast;

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_push_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef RRESP_ORPHAN_DETECT_EN
   logic r_orphan;

   // Sticky: a slave beat offered while nobody owns the channel.
   always_ff @(posedge clk) begin
      if (rst) r_orphan <= 1'b0;
      else if (s_rvalid && !w_nonempty) r_orphan <= 1'b1;
   end

   assign orphan_err = r_orphan;
`else
   assign orphan_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rresp_router.sv
// Directed testbench for axi_rresp_router (NUM_MASTERS=2, DEPTH=4).
// Checks reset, routing, ordering, full handling, wrap and orphan behaviour.
module tb_axi_rresp_router;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ar_grant;
   logic        ar_fire;
   logic        ar_block;
   logic        s_rvalid;
   logic        s_rready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic [1:0]  m_rvalid;
   logic [1:0]  m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;
   logic [2:0]  outstanding;
   logic        orphan_err;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef RRESP_ORPHAN_DETECT_EN
   localparam logic ORPHAN_EXP = 1'b1;
`else
   localparam logic ORPHAN_EXP = 1'b0;
`endif

   axi_rresp_router #(
      .NUM_MASTERS(2),
      .DATA_WIDTH (32),
      .DEPTH      (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ar_grant   (ar_grant),
      .ar_fire    (ar_fire),
      .ar_block   (ar_block),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),
      .s_rlast    (s_rlast),
      .m_rvalid   (m_rvalid),
      .m_rready   (m_rready),
      .m_rdata    (m_rdata),
      .m_rresp    (m_rresp),
      .m_rlast    (m_rlast),
      .outstanding(outstanding),
      .orphan_err (orphan_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ar_grant = 2'b00;
      ar_fire  = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = 32'h0;
      s_rresp  = 2'b00;
      s_rlast  = 1'b0;
      m_rready = 2'b00;
      #1;
   endtask

   task automatic push(input logic [1:0] g);
      ar_grant = g;
      ar_fire  = 1'b1;
      tick();
      ar_fire  = 1'b0;
      ar_grant = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      n_tests++;
      if (outstanding !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_outstanding got %0d exp 0", outstanding);
      end
      n_tests++;
      if (ar_block !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ar_block got %b exp 0", ar_block);
      end
      n_tests++;
      if (s_rready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_s_rready got %b exp 0", s_rready);
      end
      n_tests++;
      if (m_rvalid !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_m_rvalid got %b exp 00", m_rvalid);
      end
      n_tests++;
      if (orphan_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_orphan got %b exp 0", orphan_err);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_burst();
      push(2'b10);
      n_tests++;
      if (outstanding !== 3'd1) begin
         n_fail++;
         $display("FAIL single_push_cnt got %0d exp 1", outstanding);
      end
      for (int b = 0; b < 4; b++) begin
         s_rvalid = 1'b1;
         s_rdata  = 32'hA000_0000 + 32'(b);
         s_rresp  = 2'b01;
         s_rlast  = (b == 3);
         m_rready = 2'b10;
         #1;
         n_tests++;
         if (m_rvalid !== 2'b10 || s_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat%0d got mv=%b rdy=%b exp mv=10 rdy=1",
                     b, m_rvalid, s_rready);
         end
         n_tests++;
         if (m_rdata !== 32'hA000_0000 + 32'(b) || m_rresp !== 2'b01) begin
            n_fail++;
            $display("FAIL single_data%0d got %h/%b exp %h/01",
                     b, m_rdata, m_rresp, 32'hA000_0000 + 32'(b));
         end
         tick();
         n_tests++;
         if (outstanding !== ((b == 3) ? 3'd0 : 3'd1)) begin
            n_fail++;
            $display("FAIL single_cnt%0d got %0d exp %0d",
                     b, outstanding, (b == 3) ? 0 : 1);
         end
      end
      idle();
   endtask

   task automatic test_ordering();
      logic [1:0] own [3];
      own[0] = 2'b01;
      own[1] = 2'b10;
      own[2] = 2'b01;
      push(2'b01);
      push(2'b10);
      push(2'b01);
      n_tests++;
      if (outstanding !== 3'd3) begin
         n_fail++;
         $display("FAIL order_cnt got %0d exp 3", outstanding);
      end
      // Owner (master 0) stalls; only the other master is ready.
      s_rvalid = 1'b1;
      s_rdata  = 32'h1111_0000;
      s_rlast  = 1'b0;
      m_rready = 2'b10;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_tests++;
         if (s_rready !== 1'b0 || m_rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL order_stall%0d got rdy=%b mv=%b exp rdy=0 mv=01",
                     c, s_rready, m_rvalid);
         end
         tick();
      end
      n_tests++;
      if (outstanding !== 3'd3) begin
         n_fail++;
         $display("FAIL order_stall_cnt got %0d exp 3", outstanding);
      end
      for (int k = 0; k < 3; k++) begin
         for (int b = 0; b < 2; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'h2000_0000 + 32'(k * 16 + b);
            s_rlast  = (b == 1);
            m_rready = own[k];
            #1;
            n_tests++;
            if (m_rvalid !== own[k] || s_rready !== 1'b1) begin
               n_fail++;
               $display("FAIL order_b%0d_%0d got mv=%b rdy=%b exp mv=%b rdy=1",
                        k, b, m_rvalid, s_rready, own[k]);
            end
            tick();
         end
      end
      idle();
      n_tests++;
      if (outstanding !== 3'd0) begin
         n_fail++;
         $display("FAIL order_end_cnt got %0d exp 0", outstanding);
      end
   endtask

   task automatic test_full();
      logic [1:0] own [4];
      own[0] = 2'b10;
      own[1] = 2'b01;
      own[2] = 2'b10;
      own[3] = 2'b01;
      push(2'b01);
      push(2'b10);
      push(2'b01);
      push(2'b10);
      n_tests++;
      if (outstanding !== 3'd4 || ar_block !== 1'b1) begin
         n_fail++;
         $display("FAIL full_4 got cnt=%0d blk=%b exp cnt=4 blk=1",
                  outstanding, ar_block);
      end
      push(2'b10);
      n_tests++;
      if (outstanding !== 3'd4) begin
         n_fail++;
         $display("FAIL full_5th_ignored got %0d exp 4", outstanding);
      end
      // Pop while firing: block does not look ahead, so this AR is dropped.
      ar_fire  = 1'b1;
      ar_grant = 2'b10;
      s_rvalid = 1'b1;
      s_rlast  = 1'b1;
      m_rready = 2'b01;
      #1;
      n_tests++;
      if (ar_block !== 1'b1 || m_rvalid !== 2'b01 || s_rready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pop got blk=%b mv=%b rdy=%b exp blk=1 mv=01 rdy=1",
                  ar_block, m_rvalid, s_rready);
      end
      tick();
      idle();
      n_tests++;
      if (outstanding !== 3'd3 || ar_block !== 1'b0) begin
         n_fail++;
         $display("FAIL full_after_pop got cnt=%0d blk=%b exp cnt=3 blk=0",
                  outstanding, ar_block);
      end
      push(2'b01);
      n_tests++;
      if (outstanding !== 3'd4 || ar_block !== 1'b1) begin
         n_fail++;
         $display("FAIL full_refill got cnt=%0d blk=%b exp cnt=4 blk=1",
                  outstanding, ar_block);
      end
      for (int k = 0; k < 4; k++) begin
         s_rvalid = 1'b1;
         s_rlast  = 1'b1;
         m_rready = 2'b11;
         #1;
         n_tests++;
         if (m_rvalid !== own[k]) begin
            n_fail++;
            $display("FAIL full_drain%0d got %b exp %b", k, m_rvalid, own[k]);
         end
         tick();
      end
      idle();
      n_tests++;
      if (outstanding !== 3'd0) begin
         n_fail++;
         $display("FAIL full_drain_cnt got %0d exp 0", outstanding);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] g;
      for (int k = 0; k < 10; k++) begin
         g = (k % 2 == 1) ? 2'b10 : 2'b01;
         push(g);
         s_rvalid = 1'b1;
         s_rlast  = 1'b1;
         m_rready = 2'b11;
         #1;
         n_tests++;
         if (m_rvalid !== g || outstanding !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap%0d got mv=%b cnt=%0d exp mv=%b cnt=1",
                     k, m_rvalid, outstanding, g);
         end
         tick();
         idle();
      end
      n_tests++;
      if (outstanding !== 3'd0) begin
         n_fail++;
         $display("FAIL wrap_end_cnt got %0d exp 0", outstanding);
      end
   endtask

   task automatic test_orphan();
      s_rvalid = 1'b1;
      s_rdata  = 32'hDEAD_BEEF;
      s_rresp  = 2'b10;
      s_rlast  = 1'b1;
      m_rready = 2'b11;
      #1;
      n_tests++;
      if (s_rready !== 1'b0 || m_rvalid !== 2'b00) begin
         n_fail++;
         $display("FAIL orphan_route got rdy=%b mv=%b exp rdy=0 mv=00",
                  s_rready, m_rvalid);
      end
      n_tests++;
      if (m_rdata !== 32'hDEAD_BEEF || m_rresp !== 2'b10 || m_rlast !== 1'b1) begin
         n_fail++;
         $display("FAIL orphan_mirror got %h/%b/%b exp deadbeef/10/1",
                  m_rdata, m_rresp, m_rlast);
      end
      tick();
      idle();
      n_tests++;
      if (orphan_err !== ORPHAN_EXP) begin
         n_fail++;
         $display("FAIL orphan_set got %b exp %b", orphan_err, ORPHAN_EXP);
      end
      tick();
      tick();
      n_tests++;
      if (orphan_err !== ORPHAN_EXP) begin
         n_fail++;
         $display("FAIL orphan_sticky got %b exp %b", orphan_err, ORPHAN_EXP);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (orphan_err !== 1'b0) begin
         n_fail++;
         $display("FAIL orphan_clear got %b exp 0", orphan_err);
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_ordering();
      test_full();
      test_wrap();
      test_orphan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
